// File: rtl/spi_pd_ram_pkg.sv
// Shared types and elaboration helpers for the dual-port Platform Designer RAM.
package spi_pd_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } ram_state_t;

  function automatic int lanes(input int data_width);
    return data_width / 8;
  endfunction

  function automatic bit read_latency_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/spi_pd_ram_rdpipe.sv
// Per-port read-valid/data pipeline, LATENCY stages deep.
// Holds every stage while en=0 and masks the valid output until enabled again.
module spi_pd_ram_rdpipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_vld,
  input  logic [DATA_WIDTH-1:0] in_dat,
  output logic                  out_vld,
  output logic [DATA_WIDTH-1:0] out_dat
);

  logic [LATENCY-1:0]    vld_q;
  logic [DATA_WIDTH-1:0] dat_q [LATENCY];

  // Data stages only load alongside a valid so the output holds the last read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) dat_q[i] <= '0;
    end else if (en) begin
      vld_q[0] <= in_vld;
      if (in_vld) dat_q[0] <= in_dat;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_vld = vld_q[LATENCY-1] & en;
  assign out_dat = dat_q[LATENCY-1];

endmodule

// File: rtl/spi_platform_designer_dpram.sv
// True-dual-port Avalon-MM RAM with byte enables and post-reset zero-fill.
// Read data READ_LATENCY cycles after accept; both ports stall while clearing, clken=0 or reset_req=1.
module spi_platform_designer_dpram
  import spi_pd_ram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 14,
  parameter int DEPTH          = 10240,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reset_req,
  input  logic                    clken,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest,
  output logic                    init_busy
);

  localparam int BYTES = lanes(DATA_WIDTH);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  if (!read_latency_ok(READ_LATENCY) || (DATA_WIDTH % 8) != 0 || DEPTH > 2**ADDR_WIDTH) begin : g_bad_param
    $error("spi_platform_designer_dpram: illegal parameter set");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  ram_state_t            state;
  logic [IDX_W-1:0]      clr_cnt;
  logic                  en, stall, clear_we;
  logic                  s1_in_range, s2_in_range;
  logic                  s1_wr, s1_rd, s2_wr, s2_rd;
  logic [IDX_W-1:0]      s1_idx, s2_idx;
  logic [DATA_WIDTH-1:0] s1_rdat, s2_rdat;

  assign en    = clken & ~reset_req;
  assign stall = reset | (state != ST_READY) | ~en;
  assign s1_waitrequest = stall;
  assign s2_waitrequest = stall;

  assign s1_in_range = 32'(s1_address) < DEPTH;
  assign s2_in_range = 32'(s2_address) < DEPTH;
  assign s1_idx      = s1_address[IDX_W-1:0];
  assign s2_idx      = s2_address[IDX_W-1:0];

  // A simultaneous read+write on one port is treated as a write only.
  assign s1_wr = s1_chipselect & s1_write & ~stall & s1_in_range;
  assign s2_wr = s2_chipselect & s2_write & ~stall & s2_in_range;
  assign s1_rd = s1_chipselect & s1_read & ~s1_write & ~stall;
  assign s2_rd = s2_chipselect & s2_read & ~s2_write & ~stall;

  assign s1_rdat  = s1_in_range ? mem[s1_idx] : '0;
  assign s2_rdat  = s2_in_range ? mem[s2_idx] : '0;
  assign clear_we = (state == ST_CLEAR) & en & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_cnt   <= '0;
      init_busy <= (CLEAR_ON_RESET != 0);
    end else if (en && state == ST_CLEAR) begin
      if (clr_cnt == LAST_IDX) begin
        state     <= ST_READY;
        init_busy <= 1'b0;
      end else begin
        clr_cnt <= clr_cnt + IDX_W'(1);
      end
    end
  end

  // s1 lanes are applied last so they win any lane both ports write at once.
  always_ff @(posedge clk) begin
    if (clear_we) mem[clr_cnt] <= '0;
    for (int b = 0; b < BYTES; b++)
      if (s2_wr && s2_byteenable[b]) mem[s2_idx][b*8 +: 8] <= s2_writedata[b*8 +: 8];
    for (int b = 0; b < BYTES; b++)
      if (s1_wr && s1_byteenable[b]) mem[s1_idx][b*8 +: 8] <= s1_writedata[b*8 +: 8];
  end

  spi_pd_ram_rdpipe #(.DATA_WIDTH(DATA_WIDTH), .LATENCY(READ_LATENCY)) u_rdpipe_s1 (
    .clk     (clk),
    .rst     (reset),
    .en      (en),
    .in_vld  (s1_rd),
    .in_dat  (s1_rdat),
    .out_vld (s1_readdatavalid),
    .out_dat (s1_readdata)
  );

  spi_pd_ram_rdpipe #(.DATA_WIDTH(DATA_WIDTH), .LATENCY(READ_LATENCY)) u_rdpipe_s2 (
    .clk     (clk),
    .rst     (reset),
    .en      (en),
    .in_vld  (s2_rd),
    .in_dat  (s2_rdat),
    .out_vld (s2_readdatavalid),
    .out_dat (s2_readdata)
  );

endmodule

// File: tb/tb_spi_platform_designer_dpram.sv
// Directed bench: two RAM instances (read latency 1 and 2) share all inputs.
module tb_spi_platform_designer_dpram;

  localparam logic [2:0] NO = 3'b000;
  localparam logic [2:0] RD = 3'b110;
  localparam logic [2:0] WR = 3'b101;
  localparam logic [2:0] RW = 3'b111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, reset_req, clken;
  logic [4:0]  s1_address, s2_address;
  logic        s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
  logic [3:0]  s1_byteenable, s2_byteenable;
  logic [31:0] s1_writedata, s2_writedata;

  logic [31:0] a_s1_readdata, a_s2_readdata, b_s1_readdata, b_s2_readdata;
  logic        a_s1_readdatavalid, a_s2_readdatavalid, b_s1_readdatavalid, b_s2_readdatavalid;
  logic        a_s1_waitrequest, a_s2_waitrequest, b_s1_waitrequest, b_s2_waitrequest;
  logic        a_init_busy, b_init_busy;

  spi_platform_designer_dpram #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(16),
                                .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_l1 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(a_s1_readdata), .s1_readdatavalid(a_s1_readdatavalid),
    .s1_waitrequest(a_s1_waitrequest),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(a_s2_readdata), .s2_readdatavalid(a_s2_readdatavalid),
    .s2_waitrequest(a_s2_waitrequest),
    .init_busy(a_init_busy)
  );

  spi_platform_designer_dpram #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(16),
                                .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u_l2 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(b_s1_readdata), .s1_readdatavalid(b_s1_readdatavalid),
    .s1_waitrequest(b_s1_waitrequest),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(b_s2_readdata), .s2_readdatavalid(b_s2_readdatavalid),
    .s2_waitrequest(b_s2_waitrequest),
    .init_busy(b_init_busy)
  );

  typedef struct {
    bit          port;
    bit          wr;
    logic [4:0]  addr;
    logic [3:0]  be;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [14];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] got_dat [4];
  int          got_lat [4];
  int          got_cnt [4];

  function automatic vec_t mk(bit port, bit wr, logic [4:0] addr, logic [3:0] be,
                              logic [31:0] dat, logic [31:0] exp);
    vec_t v;
    v.port = port; v.wr = wr; v.addr = addr; v.be = be; v.dat = dat; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    s1_chipselect = 0; s1_read = 0; s1_write = 0; s1_address = 0; s1_byteenable = 0; s1_writedata = 0;
    s2_chipselect = 0; s2_read = 0; s2_write = 0; s2_address = 0; s2_byteenable = 0; s2_writedata = 0;
  endtask

  // One request cycle on both ports, then watch all four valid outputs for 4 cycles.
  task automatic do_cycle(input logic [2:0] c1, input logic [4:0] a1, input logic [3:0] be1,
                          input logic [31:0] d1, input logic [2:0] c2, input logic [4:0] a2,
                          input logic [3:0] be2, input logic [31:0] d2);
    logic [3:0]  vld;
    logic [31:0] dat [4];
    @(posedge clk); #1;
    {s1_chipselect, s1_read, s1_write} = c1;
    s1_address = a1; s1_byteenable = be1; s1_writedata = d1;
    {s2_chipselect, s2_read, s2_write} = c2;
    s2_address = a2; s2_byteenable = be2; s2_writedata = d2;
    @(posedge clk); #1;
    drive_idle();
    for (int j = 0; j < 4; j++) begin
      got_lat[j] = 0; got_cnt[j] = 0; got_dat[j] = 32'hDEAD0000;
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      vld = {b_s2_readdatavalid, b_s1_readdatavalid, a_s2_readdatavalid, a_s1_readdatavalid};
      dat[0] = a_s1_readdata; dat[1] = a_s2_readdata;
      dat[2] = b_s1_readdata; dat[3] = b_s2_readdata;
      for (int j = 0; j < 4; j++)
        if (vld[j]) begin
          got_cnt[j]++; got_lat[j] = k; got_dat[j] = dat[j];
        end
    end
    for (int j = 0; j < 4; j++)
      if (got_cnt[j] > 1) got_lat[j] = 99;
  endtask

  task automatic check_read(input string nm, input int p, input logic [31:0] exp);
    check({nm, " l1 data"}, got_dat[p], exp);
    check({nm, " l1 latency"}, 32'(got_lat[p]), 32'd1);
    check({nm, " l2 data"}, got_dat[p+2], exp);
    check({nm, " l2 latency"}, 32'(got_lat[p+2]), 32'd2);
  endtask

  task automatic count_busy(output int cnt, output int wr_bad);
    cnt = 0; wr_bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!a_init_busy) break;
      cnt++;
      if (!a_s1_waitrequest || !a_s2_waitrequest || !b_s1_waitrequest) wr_bad++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int          cnt, wr_bad, idx, stall_bad;
    logic [31:0] qa [$];
    logic [31:0] qb [$];
    logic [4:0]  st_addr [4];
    logic [31:0] st_exp [4];

    vecs[0]  = mk(0, 1, 5'd5,  4'hF, 32'h11223344, 32'h0);
    vecs[1]  = mk(0, 1, 5'd5,  4'h5, 32'hDEADBEEF, 32'h0);
    vecs[2]  = mk(1, 0, 5'd5,  4'h0, 32'h0,        32'h11AD33EF);
    vecs[3]  = mk(0, 1, 5'd7,  4'hF, 32'h00000001, 32'h0);
    vecs[4]  = mk(1, 1, 5'd9,  4'h8, 32'hA5A5A5A5, 32'h0);
    vecs[5]  = mk(0, 0, 5'd9,  4'h0, 32'h0,        32'hA5000000);
    vecs[6]  = mk(0, 1, 5'd2,  4'h0, 32'hFFFFFFFF, 32'h0);
    vecs[7]  = mk(1, 0, 5'd2,  4'h0, 32'h0,        32'h00000000);
    vecs[8]  = mk(0, 1, 5'd16, 4'hF, 32'h12345678, 32'h0);
    vecs[9]  = mk(0, 0, 5'd16, 4'h0, 32'h0,        32'h00000000);
    vecs[10] = mk(0, 0, 5'd0,  4'h0, 32'h0,        32'h00000000);
    vecs[11] = mk(1, 1, 5'd15, 4'hF, 32'hCAFEF00D, 32'h0);
    vecs[12] = mk(0, 0, 5'd15, 4'h0, 32'h0,        32'hCAFEF00D);
    vecs[13] = mk(1, 0, 5'd7,  4'h0, 32'h0,        32'h00000001);

    reset = 1; reset_req = 0; clken = 1;
    drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset s1 readdata", a_s1_readdata, 32'h0);
    check("reset s2 valid", {31'b0, a_s2_readdatavalid}, 32'h0);
    check("reset s1 waitrequest", {31'b0, a_s1_waitrequest}, 32'h1);
    check("reset l2 waitrequest", {31'b0, b_s2_waitrequest}, 32'h1);
    check("reset init_busy", {31'b0, a_init_busy}, 32'h1);

    @(posedge clk); #1 reset = 0;
    count_busy(cnt, wr_bad);
    check("clear busy cycles", 32'(cnt), 32'd16);
    check("clear waitrequest held", 32'(wr_bad), 32'd0);
    check("ready waitrequest", {30'b0, a_s1_waitrequest, a_s2_waitrequest}, 32'h0);
    check("ready l2 init_busy", {31'b0, b_init_busy}, 32'h0);

    for (int a = 0; a < 16; a++) begin
      do_cycle(RD, 5'(a), 4'h0, 32'h0, NO, 5'd0, 4'h0, 32'h0);
      check($sformatf("zero fill l1 addr %0d", a), got_dat[0], 32'h0);
      check($sformatf("zero fill l2 addr %0d", a), got_dat[2], 32'h0);
    end

    for (int i = 0; i < 14; i++) begin
      idx = vecs[i].port ? 1 : 0;
      if (vecs[i].wr) begin
        if (vecs[i].port)
          do_cycle(NO, 5'd0, 4'h0, 32'h0, WR, vecs[i].addr, vecs[i].be, vecs[i].dat);
        else
          do_cycle(WR, vecs[i].addr, vecs[i].be, vecs[i].dat, NO, 5'd0, 4'h0, 32'h0);
      end else begin
        if (vecs[i].port)
          do_cycle(NO, 5'd0, 4'h0, 32'h0, RD, vecs[i].addr, 4'h0, 32'h0);
        else
          do_cycle(RD, vecs[i].addr, 4'h0, 32'h0, NO, 5'd0, 4'h0, 32'h0);
        check_read($sformatf("vec%0d", i), idx, vecs[i].exp);
      end
    end

    // Write/write collision on one word.
    do_cycle(WR, 5'd3, 4'h3, 32'hAAAAAAAA, WR, 5'd3, 4'h6, 32'h55555555);
    do_cycle(RD, 5'd3, 4'h0, 32'h0, NO, 5'd0, 4'h0, 32'h0);
    check_read("ww collision", 0, 32'h0055AAAA);

    // Read on s1 while s2 writes the same word returns the old contents.
    do_cycle(RD, 5'd7, 4'h0, 32'h0, WR, 5'd7, 4'hF, 32'h00000002);
    check_read("rw collision old", 0, 32'h00000001);
    do_cycle(RD, 5'd7, 4'h0, 32'h0, NO, 5'd0, 4'h0, 32'h0);
    check_read("rw collision new", 0, 32'h00000002);

    do_cycle(RD, 5'd5, 4'h0, 32'h0, RD, 5'd5, 4'h0, 32'h0);
    check_read("rr collision s1", 0, 32'h11AD33EF);
    check_read("rr collision s2", 1, 32'h11AD33EF);

    do_cycle(RW, 5'd12, 4'hF, 32'h00000077, NO, 5'd0, 4'h0, 32'h0);
    check("read+write no valid l1", 32'(got_cnt[0]), 32'd0);
    check("read+write no valid l2", 32'(got_cnt[2]), 32'd0);
    do_cycle(RD, 5'd12, 4'h0, 32'h0, NO, 5'd0, 4'h0, 32'h0);
    check_read("read+write stored", 0, 32'h00000077);

    // Same-port write then read of that word on the very next cycle.
    @(posedge clk); #1;
    s1_chipselect = 1; s1_write = 1; s1_address = 5'd10; s1_byteenable = 4'hF; s1_writedata = 32'h0BADF00D;
    @(posedge clk); #1;
    s1_write = 0; s1_read = 1;
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    check("wr then rd l1", a_s1_readdatavalid ? a_s1_readdata : 32'hDEAD0000, 32'h0BADF00D);
    @(negedge clk);
    check("wr then rd l2", b_s1_readdatavalid ? b_s1_readdata : 32'hDEAD0000, 32'h0BADF00D);

    @(posedge clk); #1 reset_req = 1;
    @(negedge clk);
    check("reset_req stall", {30'b0, a_s1_waitrequest, b_s2_waitrequest}, 32'h3);
    @(posedge clk); #1 reset_req = 0;

    // Four back-to-back s2 reads with clken low for three cycles mid-burst.
    st_addr[0] = 5'd5;  st_exp[0] = 32'h11AD33EF;
    st_addr[1] = 5'd3;  st_exp[1] = 32'h0055AAAA;
    st_addr[2] = 5'd15; st_exp[2] = 32'hCAFEF00D;
    st_addr[3] = 5'd9;  st_exp[3] = 32'hA5000000;
    idx = 0; stall_bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      clken = (c < 2) || (c >= 5);
      if (idx < 4) begin
        s2_chipselect = 1; s2_read = 1; s2_address = st_addr[idx];
      end else begin
        drive_idle();
      end
      @(negedge clk);
      if (!clken && (!a_s2_waitrequest || a_s2_readdatavalid || b_s2_readdatavalid)) stall_bad++;
      if (a_s2_readdatavalid) qa.push_back(a_s2_readdata);
      if (b_s2_readdatavalid) qb.push_back(b_s2_readdata);
      if (idx < 4 && !a_s2_waitrequest) idx++;
    end
    check("stall outputs", 32'(stall_bad), 32'd0);
    check("burst l1 count", 32'(qa.size()), 32'd4);
    check("burst l2 count", 32'(qb.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < qa.size()) check($sformatf("burst l1 beat %0d", i), qa[i], st_exp[i]);
      if (i < qb.size()) check($sformatf("burst l2 beat %0d", i), qb[i], st_exp[i]);
    end
    @(negedge clk);
    check("readdata hold l1", a_s2_readdata, 32'hA5000000);
    check("readdata hold l2", b_s2_readdata, 32'hA5000000);

    // Reset again, then interrupt the fill after nine words.
    @(posedge clk); #1 reset = 1;
    repeat (2) @(posedge clk); #1 reset = 0;
    repeat (9) @(posedge clk); #1 reset = 1;
    @(negedge clk);
    check("mid-clear reset busy", {31'b0, a_init_busy}, 32'h1);
    @(posedge clk); #1 reset = 0;
    count_busy(cnt, wr_bad);
    check("restart busy cycles", 32'(cnt), 32'd16);
    check("restart waitrequest held", 32'(wr_bad), 32'd0);
    do_cycle(RD, 5'd15, 4'h0, 32'h0, RD, 5'd5, 4'h0, 32'h0);
    check_read("refill addr 15", 0, 32'h0);
    check_read("refill addr 5", 1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
